color_tally: RTL
================

COLOR_TALLY -- requirements
Module: color_tally

Interface
REQ-001 Parameter STABLE_N, default 4; consecutive identical non-zero samples that confirm one object (legal 1..15).
REQ-002 Parameter GAP_N, default 2; consecutive code-00 samples that re-arm after an object (legal 1..15).
REQ-003 Parameter CNT_W, default 8; width of each per-colour counter.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 sample_valid  input  1  one-cycle strobe; color_code is valid this cycle.
REQ-007 color_code  input  2  classification: 00 none, 01 red, 10 green, 11 blue.
REQ-008 clear  input  1  synchronous clear of counters and overflow.
REQ-009 obj_valid  output  1  one-cycle pulse; one object confirmed.
REQ-010 obj_color  output  2  colour of the last confirmed object; held until the next confirmation.
REQ-011 cnt_red, cnt_green, cnt_blue  output  CNT_W each  per-colour object counts.
REQ-012 overflow  output  1  sticky; a counter saturated and further increments were lost.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 Block SHALL implement FSM states IDLE, CONFIRM and LOCKED, with internal cand (2b), match_cnt (4b) and gap_cnt (4b).
REQ-015 Cycles without sample_valid SHALL leave all state unchanged; only strobed samples are evaluated.
REQ-016 IDLE: non-zero sample -> CONFIRM, cand=code, match_cnt=1; code 00 -> stay in IDLE.
REQ-017 CONFIRM: sample equal to cand -> match_cnt+1; different non-zero -> cand=code, match_cnt=1; code 00 -> IDLE, match_cnt=0.
REQ-018 When match_cnt reaches STABLE_N (from IDLE directly if STABLE_N=1), the block SHALL confirm the object and enter LOCKED with gap_cnt=0.
REQ-019 Confirmation latency: on the edge ending the completing sample_valid cycle:
- obj_valid goes high for exactly one cycle;
- obj_color updates;
- the matching counter increments.
REQ-020 LOCKED: code 00 -> gap_cnt+1, and gap_cnt reaching GAP_N -> IDLE; non-zero code -> gap_cnt=0 and stay in LOCKED (same object still present, no recount).
REQ-021 Counters SHALL saturate at all-ones; an increment at all-ones SHALL set overflow and leave the count unchanged.
REQ-022 clear SHALL zero all counters and overflow on the next edge, and SHALL NOT affect the FSM, obj_color or obj_valid.
REQ-023 If clear and an increment occur in the same cycle, clear wins:
- counter reads 0;
- obj_valid still pulses.
REQ-024 Out-of-range parameters are illegal; behaviour with them is undefined.

Reset
REQ-025 While rst=0 the block SHALL immediately force:
- state IDLE;
- cand, match_cnt and gap_cnt to 0;
- obj_valid, obj_color, all counters, overflow and busy to 0.
REQ-026 Reset asserted mid-CONFIRM or mid-LOCKED SHALL discard the partial object; the first post-reset sample is evaluated from IDLE.
REQ-027 Deassertion of rst is synchronous to clk.

Configuration
REQ-028 With macro COLOR_TALLY_TOTAL_EN defined, the block SHALL add output cnt_total (CNT_W+2 bits).
- It increments with every confirmed object, including ones lost to per-colour saturation.
- It is cleared by clear and by reset.
- It never saturates within 3*(2^CNT_W-1) objects.
REQ-029 Without COLOR_TALLY_TOTAL_EN the port and its logic SHALL be absent; all other behaviour is identical.

Verification (STABLE_N=4, GAP_N=2, CNT_W=8)
REQ-030 Samples 01,01,01,01,00,00 -> obj_valid pulses once after the 4th sample; obj_color=01, cnt_red=1, busy falls after the 6th sample.
REQ-031 Samples 10,10,11,11,11,11 -> the candidate switches at the 3rd sample; a single object is confirmed after the 6th, with cnt_blue=1 and cnt_green=0.
REQ-032 After confirming red, samples 01,00,01,00,00 -> gap resets at the 3rd sample; no recount; return to IDLE after the 5th.
REQ-033 Preload cnt_green=255 via 255 green objects, then one more green object -> cnt_green stays 255, overflow=1; a clear pulse -> cnt_green=0, overflow=0.
REQ-034 rst low after 3 matching red samples, then 4 more red samples -> exactly one object confirmed after the 4th post-reset sample.
REQ-035 clear coincident with the confirming edge of a blue object -> obj_valid=1 that cycle, cnt_blue=0 afterwards.

Source files
------------

// File: rtl/color_tally.sv
// Colour-sorter object tally: debounces strobed colour samples into objects and counts them per colour.
// Optional COLOR_TALLY_TOTAL_EN adds a non-saturating cnt_total of every confirmed object.
module color_tally #(
  parameter int unsigned STABLE_N = 4,
  parameter int unsigned GAP_N    = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [1:0]       color_code,
  input  logic             clear,
  output logic             obj_valid,
  output logic [1:0]       obj_color,
  output logic [CNT_W-1:0] cnt_red,
  output logic [CNT_W-1:0] cnt_green,
  output logic [CNT_W-1:0] cnt_blue,
  output logic             overflow,
`ifdef COLOR_TALLY_TOTAL_EN
  output logic [CNT_W+1:0] cnt_total,
`endif
  output logic             busy
);

  localparam logic [3:0] STABLE_V = 4'(STABLE_N);
  localparam logic [3:0] GAP_V    = 4'(GAP_N);
  localparam logic [1:0] C_NONE   = 2'b00;
  localparam logic [1:0] C_RED    = 2'b01;
  localparam logic [1:0] C_GREEN  = 2'b10;
  localparam logic [1:0] C_BLUE   = 2'b11;

  typedef enum logic [1:0] {IDLE, CONFIRM, LOCKED} state_t;

  state_t     state;
  logic [1:0] cand;
  logic [3:0] match_cnt;
  logic [3:0] gap_cnt;
  logic       confirm_c;

  // This strobed sample completes STABLE_N identical non-zero samples.
  always_comb begin
    confirm_c = 1'b0;
    if (sample_valid && color_code != C_NONE) begin
      if (state == IDLE && STABLE_V == 4'd1)
        confirm_c = 1'b1;
      else if (state == CONFIRM && color_code == cand && (match_cnt + 4'd1) == STABLE_V)
        confirm_c = 1'b1;
    end
  end

  // Object detection FSM with registered pulse, colour and busy flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cand      <= C_NONE;
      match_cnt <= 4'd0;
      gap_cnt   <= 4'd0;
      obj_valid <= 1'b0;
      obj_color <= C_NONE;
      busy      <= 1'b0;
    end else begin
      obj_valid <= confirm_c;
      if (confirm_c)
        obj_color <= color_code;
      if (sample_valid) begin
        case (state)
          IDLE: begin
            if (color_code != C_NONE) begin
              cand <= color_code;
              busy <= 1'b1;
              if (confirm_c) begin
                state     <= LOCKED;
                match_cnt <= STABLE_V;
                gap_cnt   <= 4'd0;
              end else begin
                state     <= CONFIRM;
                match_cnt <= 4'd1;
              end
            end
          end
          CONFIRM: begin
            if (color_code == C_NONE) begin
              state     <= IDLE;
              busy      <= 1'b0;
              match_cnt <= 4'd0;
            end else if (color_code == cand) begin
              match_cnt <= match_cnt + 4'd1;
              if (confirm_c) begin
                state   <= LOCKED;
                gap_cnt <= 4'd0;
              end
            end else begin
              cand      <= color_code;
              match_cnt <= 4'd1;
            end
          end
          LOCKED: begin
            if (color_code == C_NONE) begin
              if ((gap_cnt + 4'd1) == GAP_V) begin
                state     <= IDLE;
                busy      <= 1'b0;
                gap_cnt   <= 4'd0;
                match_cnt <= 4'd0;
                cand      <= C_NONE;
              end else begin
                gap_cnt <= gap_cnt + 4'd1;
              end
            end else begin
              // Same object still in view: hold the lock without recounting.
              gap_cnt <= 4'd0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Saturating per-colour counters; clear takes priority over an increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_red   <= '0;
      cnt_green <= '0;
      cnt_blue  <= '0;
      overflow  <= 1'b0;
    end else if (clear) begin
      cnt_red   <= '0;
      cnt_green <= '0;
      cnt_blue  <= '0;
      overflow  <= 1'b0;
    end else if (confirm_c) begin
      case (color_code)
        C_RED: begin
          if (cnt_red == '1) overflow <= 1'b1;
          else               cnt_red <= cnt_red + CNT_W'(1);
        end
        C_GREEN: begin
          if (cnt_green == '1) overflow <= 1'b1;
          else                 cnt_green <= cnt_green + CNT_W'(1);
        end
        C_BLUE: begin
          if (cnt_blue == '1) overflow <= 1'b1;
          else                cnt_blue <= cnt_blue + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef COLOR_TALLY_TOTAL_EN
  // Two extra bits cover three fully saturated colour counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_total <= '0;
    else if (clear)
      cnt_total <= '0;
    else if (confirm_c)
      cnt_total <= cnt_total + (CNT_W+2)'(1);
  end
`endif

endmodule
